// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Memory-side responder for the data cache miss interface. An accepted miss
// optionally writes the dirty victim block back to word-wide memory, then reads
// the requested block one word at a time and presents the whole block for a
// single cycle on fetch_data / fetch_enable. busy is high whenever the
// controller is not idle, so the cache can stall its pipeline.
//
// Sequence per accepted request:
//   IDLE -> WB   (BLOCK_SIZE cycles, only when the victim is dirty)
//        -> FILL (BLOCK_SIZE+1 cycles: BLOCK_SIZE reads plus one drain cycle
//                 for the one-cycle memory read latency)
//        -> RESP (1 cycle, fetch_enable pulse) -> IDLE
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_valid       miss request, only looked at while idle
//   req_addr        miss byte address (block offset bits ignored)
//   wb_valid        victim is dirty, sampled together with req_valid
//   wb_addr         victim block base address (block offset bits ignored)
//   wb_data         victim block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fetch_data      refilled block, held until the next response
//   fetch_enable    one-cycle pulse, fetch_data valid
//   busy            high in every state except idle
//   mem_addr        word-aligned memory byte address
//   mem_wr_en       memory word write strobe
//   mem_rd_en       memory word read strobe
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid one cycle after mem_rd_en
//
// Optional build macro REFILL_PERF_CNT_EN: adds miss_count / wb_count outputs
// counting accepted requests and accepted dirty requests (wrapping 32-bit).
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] wb_data,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] fetch_data,
    output logic                             fetch_enable,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_wr_en,
    output logic                             mem_rd_en,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
`ifdef REFILL_PERF_CNT_EN
    ,
    output logic [31:0]                      miss_count,
    output logic [31:0]                      wb_count
`endif
);

    localparam int WORD_IDX_W = $clog2(BLOCK_SIZE);
    localparam int BYTE_OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int BLK_OFF_W  = WORD_IDX_W + BYTE_OFF_W;
    localparam int TAG_W      = ADDR_WIDTH - BLK_OFF_W;
    localparam int CNT_W      = WORD_IDX_W + 1;
    localparam int BLK_W      = DATA_WIDTH * BLOCK_SIZE;

    // Last write-back beat, and the FILL drain beat (one past the last read).
    localparam logic [CNT_W-1:0] LAST_WB   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(BLOCK_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0]       req_tag_q;
    logic [TAG_W-1:0]       wb_tag_q;
    logic [BLK_W-1:0]       wb_data_q;
    logic [BLK_W-1:0]       fetch_data_q;

    logic                   accept;
    logic [WORD_IDX_W-1:0]  word_idx;
    logic [DATA_WIDTH-1:0]  wb_word [BLOCK_SIZE];
    logic [BLK_W-1:0]       fill_block;
    logic                   unused_addr_bits;

    // A request is only honoured while idle; anything arriving while busy is
    // dropped and must be re-asserted by the cache.
    assign accept   = (state_q == S_IDLE) && req_valid;

    // Only the low counter bits form the word offset; the extra counter bit
    // exists solely to count the FILL drain beat.
    assign word_idx = cnt_q[WORD_IDX_W-1:0];

    // Block offset bits of both addresses are don't-care.
    assign unused_addr_bits = ^{req_addr[BLK_OFF_W-1:0], wb_addr[BLK_OFF_W-1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture: addresses and victim data are frozen at acceptance so
    // the cache is free to change its inputs while we work.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tag_q <= '0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            req_tag_q <= req_addr[ADDR_WIDTH-1:BLK_OFF_W];
            wb_tag_q  <= wb_addr[ADDR_WIDTH-1:BLK_OFF_W];
            wb_data_q <= wb_data;
        end
    end

    genvar gi;

    // Victim block split into words for the write-back mux.
    generate
        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_wb_word
            assign wb_word[gi] = wb_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Fill buffer. Read data for word k arrives on FILL beat k+1. The last word
    // arrives on the drain beat and goes straight into fetch_data_q, so only
    // BLOCK_SIZE-1 words need holding registers.
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < BLOCK_SIZE - 1; gi++) begin : g_fill
            logic [DATA_WIDTH-1:0] word_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else if ((state_q == S_FILL) && (cnt_q == CNT_W'(gi + 1))) begin
                    word_q <= mem_rdata;
                end
            end

            assign fill_block[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
        end
    endgenerate

    assign fill_block[BLK_W-1 -: DATA_WIDTH] = mem_rdata;

    // fetch_data only changes when a new block is completed, so it stays
    // stable through idle periods between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_data_q <= '0;
        end else if ((state_q == S_FILL) && (cnt_q == LAST_FILL)) begin
            fetch_data_q <= fill_block;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_enable = 1'b0;
        mem_addr     = '0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = wb_valid ? S_WB : S_FILL;
                    cnt_d   = '0;
                end
            end

            S_WB: begin
                mem_wr_en = 1'b1;
                mem_addr  = {wb_tag_q, word_idx, {BYTE_OFF_W{1'b0}}};
                mem_wdata = wb_word[word_idx];
                if (cnt_q == LAST_WB) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FILL: begin
                // Reads are issued on beats 0..BLOCK_SIZE-1; the final beat
                // only waits for the last read word.
                if (cnt_q < LAST_FILL) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = {req_tag_q, word_idx, {BYTE_OFF_W{1'b0}}};
                end
                if (cnt_q == LAST_FILL) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                fetch_enable = 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign fetch_data = fetch_data_q;

`ifdef REFILL_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters, wrapping naturally at 2^32.
    // -------------------------------------------------------------------------
    logic [31:0] miss_count_q;
    logic [31:0] wb_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else if (accept) begin
            miss_count_q <= miss_count_q + 32'd1;
            if (wb_valid) begin
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cache_refill_ctrl.
// A word-wide memory with one-cycle read latency sits on the memory port. The
// reference model keeps its own shadow of memory and computes, per miss, the
// expected write sequence, read sequence, response cycle and returned block.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [127:0] fetch_data;
    logic         fetch_enable;
    logic         busy;
    logic [31:0]  mem_addr;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
`ifdef REFILL_PERF_CNT_EN
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_miss = 0;
    int exp_wb   = 0;

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .fetch_data   (fetch_data),
        .fetch_enable (fetch_enable),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef REFILL_PERF_CNT_EN
        ,
        .miss_count   (miss_count),
        .wb_count     (wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Memory: initial contents come from init_word; written words override.
    // Block 0x1020 holds 0xA0..0xA3, block 0x1040 holds 0xB0..0xB3.
    // ---------------------------------------------------------------------
    function automatic logic [31:0] init_word(input logic [11:0] idx);
        if (idx >= 12'h408 && idx <= 12'h40B) return 32'hA0 + 32'(idx - 12'h408);
        if (idx >= 12'h410 && idx <= 12'h413) return 32'hB0 + 32'(idx - 12'h410);
        return {20'h5EED0, idx};
    endfunction

    logic [31:0] mem_val     [4096];
    bit          mem_written [4096];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem_val[mem_addr[13:2]]     <= mem_wdata;
            mem_written[mem_addr[13:2]] <= 1'b1;
        end
        if (mem_rd_en) begin
            mem_rdata <= mem_written[mem_addr[13:2]] ? mem_val[mem_addr[13:2]]
                                                     : init_word(mem_addr[13:2]);
        end
    end

    // ---------------------------------------------------------------------
    // Reference model shadow memory
    // ---------------------------------------------------------------------
    logic [31:0] ref_val [4096];
    bit          ref_wr  [4096];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[13:2]] ? ref_val[a[13:2]] : init_word(a[13:2]);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        ref_val[a[13:2]] = d;
        ref_wr[a[13:2]]  = 1'b1;
    endtask

    // One miss at the model level: victim written back in full, then the
    // requested block read back. Response is seen by the edge at T+6 (clean)
    // or T+10 (dirty), i.e. in cycle 5 / 9 counting from the accept edge.
    task automatic model_txn(input logic [31:0] a, input logic wbv,
                             input logic [31:0] wa, input logic [127:0] wd,
                             output logic [127:0] exp_data, output int exp_n);
        logic [31:0] wbase;
        logic [31:0] rbase;
        wbase = {wa[31:4], 4'h0};
        rbase = {a[31:4], 4'h0};
        exp_miss++;
        if (wbv) begin
            exp_wb++;
            for (int k = 0; k < 4; k++) ref_write(wbase + 32'(4 * k), wd[k*32 +: 32]);
        end
        for (int k = 0; k < 4; k++) exp_data[k*32 +: 32] = ref_read(rbase + 32'(4 * k));
        exp_n = (wbv ? 10 : 6) - 1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fetch_data"},   fetch_data,   128'h0);
        check({pfx, "_fetch_enable"}, fetch_enable, 128'h0);
        check({pfx, "_busy"},         busy,         128'h0);
        check({pfx, "_mem_addr"},     mem_addr,     128'h0);
        check({pfx, "_mem_wr_en"},    mem_wr_en,    128'h0);
        check({pfx, "_mem_rd_en"},    mem_rd_en,    128'h0);
        check({pfx, "_mem_wdata"},    mem_wdata,    128'h0);
    endtask

    // Bus rules checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", {126'h0, mem_wr_en, mem_rd_en} == 128'h3, 128'h0);
            if (!busy) check("idle_no_mem_strobe", {126'h0, mem_wr_en, mem_rd_en}, 128'h0);
        end
    end

    // Drive one request from idle and observe a fixed 12-cycle window.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic wbv,
                           input logic [31:0] wa, input logic [127:0] wd,
                           input logic [127:0] exp_data, input int exp_n);
        logic [31:0]  wr_a [8];
        logic [31:0]  wr_d [8];
        logic [31:0]  rd_a [8];
        int           wr_n [8];
        int           rd_n [8];
        int           nw, nr, nf, f_n;
        logic [127:0] f_d;
        logic         busy_end;
        logic [127:0] hold;
        logic [31:0]  wbase;
        logic [31:0]  rbase;
        int           rd_off;
        nw = 0; nr = 0; nf = 0; f_n = -1; f_d = '0;
        wbase = {wa[31:4], 4'h0};
        rbase = {a[31:4], 4'h0};

        @(negedge clk);
        req_valid = 1'b1; req_addr = a; wb_valid = wbv; wb_addr = wa; wb_data = wd;
        @(posedge clk);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 0) begin
                req_valid = 1'b0;
                wb_valid  = 1'b0;
            end
            if (mem_wr_en) begin
                if (nw < 8) begin wr_a[nw] = mem_addr; wr_d[nw] = mem_wdata; wr_n[nw] = n; end
                nw++;
            end
            if (mem_rd_en) begin
                if (nr < 8) begin rd_a[nr] = mem_addr; rd_n[nr] = n; end
                nr++;
            end
            if (fetch_enable) begin
                nf++;
                f_n = n;
                f_d = fetch_data;
            end
        end
        busy_end = busy;
        hold     = fetch_data;

        check({tag, "_wr_count"}, nw, wbv ? 4 : 0);
        for (int k = 0; k < 4 && k < nw; k++) begin
            check({tag, "_wr_addr"},  wr_a[k], wbase + 32'(4 * k));
            check({tag, "_wr_data"},  wr_d[k], wd[k*32 +: 32]);
            check({tag, "_wr_cycle"}, wr_n[k], k);
        end
        rd_off = wbv ? 4 : 0;
        check({tag, "_rd_count"}, nr, 4);
        for (int k = 0; k < 4 && k < nr; k++) begin
            check({tag, "_rd_addr"},  rd_a[k], rbase + 32'(4 * k));
            check({tag, "_rd_cycle"}, rd_n[k], rd_off + k);
        end
        check({tag, "_fetch_pulses"}, nf, 1);
        check({tag, "_fetch_cycle"},  f_n, exp_n);
        check({tag, "_fetch_data"},   f_d, exp_data);
        check({tag, "_busy_after"},   busy_end, 1'b0);
        check({tag, "_fetch_hold"},   hold, exp_data);
        $display("txn %s req=%h wb=%0d wb_addr=%h fetch_cycle=%0d data=%h",
                 tag, a, wbv, wa, f_n, f_d);
    endtask

    typedef struct {
        logic [31:0]  req_addr;
        logic         wb_valid;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic [127:0] exp_data;
        int           exp_n;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [127:0] mdata;
        int           mn;
        logic [12:0]  rd_mask, f_mask, b_mask;
        logic [31:0]  ra, wa;
        logic         wbv;
        logic [127:0] wd;

        vecs[0] = '{32'h0000_1024, 1'b0, 32'h0, 128'h0,
                    128'h000000A3_000000A2_000000A1_000000A0, 5};
        vecs[1] = '{32'h0000_1048, 1'b1, 32'h0000_2010,
                    128'h00000044_00000033_00000022_00000011,
                    128'h000000B3_000000B2_000000B1_000000B0, 9};
        vecs[2] = '{32'h0000_3000, 1'b1, 32'h0000_3000,
                    128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000,
                    128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, 9};
        vecs[3] = '{32'h0000_102C, 1'b1, 32'h0000_201F,
                    128'h5555000D_5555000C_5555000B_5555000A,
                    128'h000000A3_000000A2_000000A1_000000A0, 9};
        vecs[4] = '{32'h0000_2014, 1'b0, 32'h0, 128'h0,
                    128'h5555000D_5555000C_5555000B_5555000A, 5};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed table: expectations are constants; the model is kept in step.
        for (int i = 0; i < 5; i++) begin
            model_txn(vecs[i].req_addr, vecs[i].wb_valid, vecs[i].wb_addr,
                      vecs[i].wb_data, mdata, mn);
            run_txn($sformatf("vec%0d", i), vecs[i].req_addr, vecs[i].wb_valid,
                    vecs[i].wb_addr, vecs[i].wb_data, vecs[i].exp_data, vecs[i].exp_n);
        end

        // req_valid held high: one transaction per idle visit, none during RESP.
        model_txn(32'h0000_1020, 1'b0, 32'h0, 128'h0, mdata, mn);
        model_txn(32'h0000_1020, 1'b0, 32'h0, 128'h0, mdata, mn);
        rd_mask = '0; f_mask = '0; b_mask = '0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_1020; wb_valid = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            rd_mask[n] = mem_rd_en;
            f_mask[n]  = fetch_enable;
            b_mask[n]  = busy;
            if (fetch_enable) check("held_req_fetch_data", fetch_data, mdata);
            if (n == 12) req_valid = 1'b0;
        end
        check("held_req_rd_pattern",    rd_mask, 13'h078F);
        check("held_req_fetch_pattern", f_mask,  13'h1020);
        check("held_req_busy_pattern",  b_mask,  13'h1FBF);
        @(negedge clk);
        check("held_req_idle_after", busy, 1'b0);
        $display("txn held_req rd_mask=%h fetch_mask=%h busy_mask=%h", rd_mask, f_mask, b_mask);

        // Reset during the third write-back beat.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0900; wb_valid = 1'b1;
        wb_addr = 32'h0000_0800; wb_data = 128'h77770003_77770002_77770001_77770000;
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (n == 0) begin req_valid = 1'b0; wb_valid = 1'b0; end
        end
        check("midwb_third_wr_en",   mem_wr_en, 1'b1);
        check("midwb_third_wr_addr", mem_addr,  32'h0000_0808);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midwb_reset");
        rst = 1'b0;
        $display("txn midwb_reset victim=00000800 aborted after third write");
        // The third write was already on the bus at the reset edge.
        ref_write(32'h0000_0800, 32'h77770000);
        ref_write(32'h0000_0804, 32'h77770001);
        ref_write(32'h0000_0808, 32'h77770002);
        exp_miss = 0;
        exp_wb   = 0;
        model_txn(32'h0000_0800, 1'b0, 32'h0, 128'h0, mdata, mn);
        run_txn("after_reset", 32'h0000_0800, 1'b0, 32'h0, 128'h0, mdata, mn);

        // Randomized misses against the model.
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom_range(0, 32'h3FFF);
            wbv = 1'($urandom_range(0, 1));
            wa  = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 32'h3FFF);
            wd  = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model_txn(ra, wbv, wa, wd, mdata, mn);
            run_txn($sformatf("rand%0d", i), ra, wbv, wa, wd, mdata, mn);
        end

`ifdef REFILL_PERF_CNT_EN
        check("miss_count", miss_count, 32'(exp_miss));
        check("wb_count",   wb_count,   32'(exp_wb));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
